// File: rtl/ppu_sparse_compressor.sv
// ppu_sparse_compressor: optional ReLU, zero-run-length encoding and packing of nonzeros into
// NUM_OUT-lane groups for activation RAM write-back. A build buffer feeds one output register.
module ppu_sparse_compressor #(
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 4,
    parameter int NUM_OUT = 4,
    parameter int CH_W    = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic                       i_relu_en,
    input  logic [CH_W-1:0]            i_num_ch,
    input  logic                       i_in_valid,
    input  logic [DATA_W-1:0]          i_in_data,
    input  logic                       i_in_last,
    output logic                       o_in_ready,
    output logic [NUM_OUT-1:0]         o_out_valid,
    output logic [NUM_OUT*DATA_W-1:0]  o_out_data,
    output logic [NUM_OUT*IDX_W-1:0]   o_out_indices,
    output logic [CH_W-1:0]            o_out_channel,
    input  logic                       i_out_ready,
    output logic                       o_busy,
    output logic                       o_done
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_RUN   | accepting dense elements
    // S_FLUSH | last channel seen, draining build buffer and output register
    // S_DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam int               CNT_W    = $clog2(NUM_OUT + 1);
    localparam logic [IDX_W-1:0] MAX_RUN  = '1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_OUT);

    state_t r_state, w_state_nxt;

    logic                 r_relu;
    logic [CH_W-1:0]      r_num_ch;
    logic [CH_W-1:0]      r_ch;
    logic [IDX_W-1:0]     r_run;

    logic [DATA_W-1:0]    r_b_data [NUM_OUT];
    logic [IDX_W-1:0]     r_b_idx  [NUM_OUT];
    logic [CNT_W-1:0]     r_b_cnt;
    logic                 r_b_closed;
    logic [CH_W-1:0]      r_b_ch;

    logic [NUM_OUT-1:0]         r_o_valid;
    logic [NUM_OUT*DATA_W-1:0]  r_o_data;
    logic [NUM_OUT*IDX_W-1:0]   r_o_idx;
    logic [CH_W-1:0]            r_o_ch;

    logic                 w_out_hs;
    logic                 w_out_free;
    logic                 w_in_ready;
    logic                 w_acc;
    logic [DATA_W-1:0]    w_val;
    logic                 w_emit;
    logic [CNT_W-1:0]     w_base_cnt;
    logic                 w_last_ch;

    logic [DATA_W-1:0]    w_nb_data [NUM_OUT];
    logic [IDX_W-1:0]     w_nb_idx  [NUM_OUT];
    logic [CNT_W-1:0]     w_nb_cnt;
    logic [CH_W-1:0]      w_nb_ch;
    logic                 w_nb_close;

    logic                 w_hold_b;
    logic                 w_ld_b;
    logic                 w_ld_nb;
    logic [CNT_W-1:0]     w_src_cnt;
    logic [NUM_OUT-1:0]         w_ld_valid;
    logic [NUM_OUT*DATA_W-1:0]  w_ld_data;
    logic [NUM_OUT*IDX_W-1:0]   w_ld_idx;
    logic [CH_W-1:0]            w_ld_ch;

    assign w_out_hs   = (|r_o_valid) && i_out_ready;
    assign w_out_free = !(|r_o_valid) || i_out_ready;
    assign w_in_ready = (r_state == S_RUN) && !(r_b_closed && !w_out_free);
    assign w_acc      = i_in_valid && w_in_ready;
    assign w_val      = (r_relu && i_in_data[DATA_W-1]) ? '0 : i_in_data;
    assign w_emit     = w_acc && ((w_val != '0) || (r_run == MAX_RUN));
    // A closed buffer that is accepting again is moving out this cycle, so new data starts at lane 0.
    assign w_base_cnt = r_b_closed ? '0 : r_b_cnt;
    assign w_last_ch  = (r_ch == r_num_ch - CH_W'(1));

    always_comb begin
        w_nb_data = r_b_data;
        w_nb_idx  = r_b_idx;
        w_nb_ch   = r_b_ch;
        w_nb_cnt  = w_base_cnt;
        if (w_emit) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_base_cnt == CNT_W'(i)) begin
                    w_nb_data[i] = w_val;
                    w_nb_idx[i]  = r_run;
                end
            end
            w_nb_cnt = w_base_cnt + CNT_W'(1);
            if (w_base_cnt == '0) w_nb_ch = r_ch;
        end
        w_nb_close = (w_nb_cnt == FULL_CNT) || (w_acc && i_in_last && (w_nb_cnt != '0));
    end

    assign w_hold_b = r_b_closed && !w_out_free;
    assign w_ld_b   = r_b_closed && w_out_free;
    assign w_ld_nb  = !r_b_closed && w_nb_close && w_out_free;

    always_comb begin
        w_ld_valid = '0;
        w_ld_data  = '0;
        w_ld_idx   = '0;
        w_src_cnt  = w_ld_b ? r_b_cnt : w_nb_cnt;
        w_ld_ch    = w_ld_b ? r_b_ch : w_nb_ch;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (CNT_W'(i) < w_src_cnt) begin
                w_ld_valid[i]                = 1'b1;
                w_ld_data[i*DATA_W +: DATA_W] = w_ld_b ? r_b_data[i] : w_nb_data[i];
                w_ld_idx[i*IDX_W +: IDX_W]    = w_ld_b ? r_b_idx[i] : w_nb_idx[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_acc && i_in_last && w_last_ch) w_state_nxt = S_FLUSH;
            S_FLUSH: if (!r_b_closed && (r_b_cnt == '0) && w_out_free) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_relu     <= 1'b0;
            r_num_ch   <= '0;
            r_ch       <= '0;
            r_run      <= '0;
            r_b_cnt    <= '0;
            r_b_closed <= 1'b0;
            r_b_ch     <= '0;
            for (int i = 0; i < NUM_OUT; i++) begin
                r_b_data[i] <= '0;
                r_b_idx[i]  <= '0;
            end
            r_o_valid  <= '0;
            r_o_data   <= '0;
            r_o_idx    <= '0;
            r_o_ch     <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_relu   <= i_relu_en;
                r_num_ch <= (i_num_ch == '0) ? CH_W'(1) : i_num_ch;
                r_ch     <= '0;
                r_run    <= '0;
            end else if (w_acc) begin
                r_run <= (i_in_last || w_emit) ? '0 : r_run + IDX_W'(1);
                if (i_in_last) r_ch <= r_ch + CH_W'(1);
            end

            if (w_ld_nb) begin
                r_b_cnt    <= '0;
                r_b_closed <= 1'b0;
            end else if (!w_hold_b) begin
                r_b_data   <= w_nb_data;
                r_b_idx    <= w_nb_idx;
                r_b_cnt    <= w_nb_cnt;
                r_b_ch     <= w_nb_ch;
                r_b_closed <= w_nb_close;
            end

            if (w_ld_b || w_ld_nb) begin
                r_o_valid <= w_ld_valid;
                r_o_data  <= w_ld_data;
                r_o_idx   <= w_ld_idx;
                r_o_ch    <= w_ld_ch;
            end else if (w_out_hs) begin
                r_o_valid <= '0;
                r_o_data  <= '0;
                r_o_idx   <= '0;
                r_o_ch    <= '0;
            end
        end
    end

    assign o_in_ready    = w_in_ready;
    assign o_out_valid   = r_o_valid;
    assign o_out_data    = r_o_data;
    assign o_out_indices = r_o_idx;
    assign o_out_channel = r_o_ch;
    assign o_busy        = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign o_done        = (r_state == S_DONE);

endmodule
